// File: rtl/uio_pkg.sv
// Shared definitions for the HPS user-I/O command channel: command codes,
// config bit positions, decoder states and the status read-back word.
package uio_pkg;

    localparam logic [7:0] UIO_CMD_CFG  = 8'h01;
    localparam logic [7:0] UIO_CMD_CFGN = 8'h02;
    localparam logic [7:0] UIO_CMD_STAT = 8'h03;

    localparam int CFG_DVI    = 7;
    localparam int CFG_A96K   = 6;
    localparam int CFG_YPBPR  = 5;
    localparam int CFG_CSYNC  = 3;
    localparam int CFG_VGASCL = 2;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CMD  = 3'd1,
        WR1  = 3'd2,
        WRN  = 3'd3,
        STAT = 3'd4,
        SKIP = 3'd5
    } uio_state_e;

    // Status word presented for a given read-back slot.
    function automatic logic [15:0] stat_word(
        input logic [1:0]  idx,
        input logic [15:0] ver,
        input logic        btn_osd,
        input logic        btn_user
    );
        case (idx)
            2'd0:    stat_word = ver;
            2'd1:    stat_word = {14'd0, btn_osd, btn_user};
            default: stat_word = 16'h0000;
        endcase
    endfunction

endpackage

// File: rtl/uio_cfg_decoder.sv
// UIO command decoder: owns the main config word, the extended config bank
// and the status read-back path toward the HPS.
module uio_cfg_decoder
    import uio_pkg::*;
#(
    parameter int          CFG_WORDS = 4,
    parameter logic [15:0] VER       = 16'h0001
) (
    input  logic                      clk_sys,
    input  logic                      reset,
    input  logic                      io_uio,
    input  logic                      io_strobe,
    input  logic [15:0]               io_din,
    output logic [15:0]               io_dout,
    input  logic                      btn_user,
    input  logic                      btn_osd,
    output logic [15:0]               cfg,
    output logic [16*CFG_WORDS-1:0]   cfg_bank,
    output logic                      cfg_ready,
    output logic                      cfg_stb
);

    logic                        old_strobe_r;
    logic                        stb_edge_s;
    uio_state_e                  state_r;
    logic [4:0]                  index_r;
    logic [4:0]                  stat_next_s;
    logic [15:0]                 cfg_r;
    logic [15:0]                 io_dout_r;
    logic [CFG_WORDS-1:0][15:0]  bank_r;
    logic                        cfg_ready_r;
    logic                        cfg_stb_r;

    assign stb_edge_s = io_strobe & ~old_strobe_r;

    // Next read-back slot; the index parks at 3 once past the defined words.
    always_comb begin
        stat_next_s = 5'd3;
        if (index_r < 5'd3) begin
            stat_next_s = index_r + 5'd1;
        end else begin
            stat_next_s = 5'd3;
        end
    end

    // Strobe edge history, command FSM and all registered outputs.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            old_strobe_r <= 1'b0;
            state_r      <= IDLE;
            index_r      <= 5'd0;
            cfg_r        <= 16'h0000;
            io_dout_r    <= 16'h0000;
            bank_r       <= '0;
            cfg_ready_r  <= 1'b0;
            cfg_stb_r    <= 1'b0;
        end else begin
            old_strobe_r <= io_strobe;
            cfg_stb_r    <= 1'b0;
            // Abort has priority over any word arriving in the same cycle.
            if (!io_uio) begin
                state_r   <= IDLE;
                index_r   <= 5'd0;
                io_dout_r <= 16'h0000;
            end else begin
                case (state_r)
                    IDLE, CMD: begin
                        if (stb_edge_s) begin
                            index_r <= 5'd0;
                            case (io_din[7:0])
                                UIO_CMD_CFG:  state_r <= WR1;
                                UIO_CMD_CFGN: state_r <= WRN;
                                UIO_CMD_STAT: begin
                                    state_r   <= STAT;
                                    io_dout_r <= VER;
                                end
                                default:      state_r <= SKIP;
                            endcase
                        end else begin
                            state_r <= CMD;
                        end
                    end
                    WR1: begin
                        if (stb_edge_s) begin
                            cfg_r       <= io_din;
                            cfg_ready_r <= 1'b1;
                            cfg_stb_r   <= 1'b1;
                            state_r     <= SKIP;
                        end
                    end
                    WRN: begin
                        if (stb_edge_s && (index_r < 5'(CFG_WORDS))) begin
                            for (int i = 0; i < CFG_WORDS; i++) begin
                                if (index_r == 5'(i)) begin
                                    bank_r[i] <= io_din;
                                end
                            end
                            cfg_stb_r <= 1'b1;
                            index_r   <= index_r + 5'd1;
                        end
                    end
                    STAT: begin
                        if (stb_edge_s) begin
                            index_r   <= stat_next_s;
                            io_dout_r <= stat_word(stat_next_s[1:0], VER, btn_osd, btn_user);
                        end
                    end
                    SKIP: begin
                        state_r <= SKIP;
                    end
                    default: begin
                        state_r <= IDLE;
                    end
                endcase
            end
        end
    end

    assign io_dout   = io_dout_r;
    assign cfg       = cfg_r;
    assign cfg_bank  = bank_r;
    assign cfg_ready = cfg_ready_r;
    assign cfg_stb   = cfg_stb_r;

endmodule

// File: doc/uio_cfg_decoder.md
Name: uio_cfg_decoder

Overview:
- Parses the HPS user-I/O (UIO) command channel on clk_sys.
- The first 16-bit word of each UIO transaction is the command. Following words are payload (config writes) or read-back slots (status).
- Owns the system config register (video/audio mode bits), a small bank of extra config words, and the status read-back path to io_dout.
- Sits between the HPS GP-bus handshake logic (io_strobe/io_din producer) and the HDMI/audio/VGA config consumers.

Parameters:
- CFG_WORDS, 4, number of 16-bit words in the extended config bank (1..16).
- VER, 16'h0001, value returned as status word 0.

Ports:
- clk_sys  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- io_uio  in  1  UIO transaction enable; low = no transaction / abort.
- io_strobe  in  1  word strobe from the HPS handshake. Level signal; only its rising edge counts.
- io_din  in  16  word from HPS; sampled on the strobe rising edge.
- io_dout  out  16  read-back word for the HPS.
- btn_user  in  1  debounced user button, reported in status.
- btn_osd  in  1  debounced OSD button, reported in status.
- cfg  out  16  main config word (bit7 dvi, bit6 audio_96k, bit5 ypbpr, bit3 csync, bit2 vga_scaler).
- cfg_bank  out  16*CFG_WORDS  extended config words; word i is at bits [16*i+15:16*i].
- cfg_ready  out  1  sticky flag: main config written at least once.
- cfg_stb  out  1  one-cycle pulse on any config write.

Behaviour:
- Reset values: cfg=0, cfg_bank=0, cfg_ready=0, cfg_stb=0, io_dout=0, state=IDLE, index=0, old_strobe=0.
- Edge detect: a registered old_strobe gives stb_edge = io_strobe & ~old_strobe. Exactly one word is consumed per edge.
- io_uio low in any state forces state to IDLE next cycle. The index clears, io_dout is driven to 0, and no write occurs in that cycle even if stb_edge is high.
- IDLE: io_uio high moves to CMD. A stb_edge in the same cycle is accepted as the command word.
- CMD: on stb_edge, latch io_din[7:0] as the command, clear the index, and branch:
  - 0x01 → WR1.
  - 0x02 → WRN.
  - 0x03 → STAT; io_dout = VER valid from the next cycle.
  - any other value → SKIP.
- WR1: on the first stb_edge, cfg <= io_din, cfg_ready <= 1, cfg_stb pulses for 1 cycle, then go to SKIP. Further words are ignored.
- WRN: on each stb_edge with index < CFG_WORDS:
  - cfg_bank[index] <= io_din, cfg_stb pulses, index increments.
  - At index == CFG_WORDS, stay in WRN and ignore words. No wrap-around.
- STAT: io_dout is registered and updated the cycle after each stb_edge. Sequence by index:
  - index 0 → VER.
  - index 1 → {14'd0, btn_osd, btn_user}.
  - index ≥ 2 → 16'h0000.
  - Index saturates at 3.
  - Button values are sampled at the edge that advances the index.
- SKIP: absorbs all words until io_uio drops.
- cfg_ready clears only on reset; a new transaction never clears it.
- Simultaneous stb_edge and io_uio falling: the abort wins, and the word is dropped.
- Reset mid-transaction: everything returns to reset values. A new command word is needed after io_uio next rises. If io_uio is still high at reset release, go to CMD first.
- Latency: config outputs update 1 cycle after stb_edge; io_dout updates 1 cycle after stb_edge.

Decomposition:
- Shared package uio_pkg:
  - Command constants UIO_CMD_CFG=8'h01, UIO_CMD_CFGN=8'h02, UIO_CMD_STAT=8'h03.
  - cfg bit-index constants: CFG_DVI=7, CFG_A96K=6, CFG_YPBPR=5, CFG_CSYNC=3, CFG_VGASCL=2.
  - State enum: IDLE, CMD, WR1, WRN, STAT, SKIP.
- Single module; no sub-module. The strobe edge detector stays inline.

Test Plan:
- io_uio=1; strobes 0x0001, 0x00C4 → cfg=16'h00C4, cfg_ready=1, one cfg_stb pulse. A third strobe 0xFFFF leaves cfg unchanged.
- Command 0x02 with CFG_WORDS=4, then 6 words 0x1111..0x6666 → cfg_bank = {0x4444,0x3333,0x2222,0x1111}, exactly 4 cfg_stb pulses, words 5-6 ignored.
- Command 0x03 with btn_user=1, btn_osd=0, VER=0x0001 → io_dout reads 0x0001, then 0x0001 (buttons) after the 2nd strobe, then 0x0000; io_uio low → io_dout=0.
- Command 0x02, 2 words, io_uio drops, then a new transaction 0x02 + 0xAAAA → bank[0]=0xAAAA (index restarted), bank[1] keeps its old value.
- io_strobe held high for 10 cycles after command 0x01 → counted as one word; cfg written once, single cfg_stb.
- Reset asserted mid-WRN after 1 word → all outputs 0, cfg_ready=0. Command 0x99 then words → no outputs change (SKIP).
